// File: rtl/ddc_stream_sender.sv
// ddc_stream_sender
//   Round-robin packetiser for NR DDC receive streams on the Ethernet
//   transmit path. It scans the stream ready flags and picks one ready
//   stream. It then frames one UDP payload for that stream and hands it to
//   the UDP/IP transmitter a byte at a time.
//
//   Frame layout (big-endian header, then interleaved I/Q bytes):
//     bytes  0..3   per-stream sequence number
//     bytes  4..11  64-bit timestamp, latched when the packet is set up
//     bytes 12..13  bits per sample (24 or 16)
//     bytes 14..15  samples per frame
//     bytes 16..    sample bytes taken from the selected stream's rx_data
//
// Ports
//   tx_clock           transmit clock; all logic uses its rising edge
//   reset_n            asynchronous active-low reset
//   run                streaming enable
//   sample24           1 = 24-bit samples (6 bytes per I/Q pair), 0 = 16-bit (4 bytes)
//   samples_per_frame  I/Q samples per packet (1..255)
//   fifo_ready[NR]     stream k holds a complete frame
//   rx_data[8*NR]      byte k*8+:8 is the output of stream k's FIFO
//   udp_tx_enable      transmitter grants the pending request
//   udp_tx_active      transmitter consumes udp_tx_data this cycle
//   udp_tx_request     a packet is pending or being sent
//   udp_tx_length      UDP payload length in bytes
//   udp_tx_data        current payload byte
//   port_ID            source-port offset (PORT_BASE + stream)
//   fifo_rdreq[NR]     read strobe for each stream
//   phy_ready          no DDC packet in progress or pending
module ddc_stream_sender #(
  parameter int NR        = 4,
  parameter int PORT_BASE = 11,
  parameter int TIMEOUT   = 250000000
) (
  input  logic            tx_clock,
  input  logic            reset_n,
  input  logic            run,
  input  logic            sample24,
  input  logic [15:0]     samples_per_frame,
  input  logic [NR-1:0]   fifo_ready,
  input  logic [8*NR-1:0] rx_data,
  input  logic            udp_tx_enable,
  input  logic            udp_tx_active,
  output logic            udp_tx_request,
  output logic [15:0]     udp_tx_length,
  output logic [7:0]      udp_tx_data,
  output logic [7:0]      port_ID,
  output logic [NR-1:0]   fifo_rdreq,
  output logic            phy_ready
);

  localparam int PW = (NR > 1) ? $clog2(NR) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, SEND} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_next, sel;
  logic [31:0]     seq [NR];
  logic [63:0]     ts, ts_lat;
  logic            s24_lat;
  logic [15:0]     spf_lat;
  logic [15:0]     byte_no;
  logic [WW-1:0]   wd;
  logic            timeout;
  logic            last_byte;
  logic            rd_window;
  logic [31:0]     seq_sel;
  logic [7:0]      rx_sel;

  assign seq_sel   = seq[sel];
  assign rx_sel    = rx_data[8*sel +: 8];
  assign ptr_next  = (ptr == PW'(NR - 1)) ? '0 : ptr + PW'(1);
  assign last_byte = (state == SEND) && (byte_no == udp_tx_length);
  // The FIFO output trails its read strobe by two consumed bytes, so reads
  // start at byte 13 to put the first sample byte on rx_data at byte 16.
  assign rd_window = (byte_no >= 16'd13) && (byte_no <= udp_tx_length - 16'd4);
  assign timeout   = (state != IDLE) && !run && (wd == WW'(TIMEOUT - 1));

  // Byte idx of the frame being sent; header from the per-packet latches,
  // everything past the header straight from the selected stream.
  function automatic logic [7:0] frame_byte(input logic [15:0] idx);
    logic [7:0]  b;
    logic [15:0] bits;
    bits = s24_lat ? 16'd24 : 16'd16;
    case (idx)
      16'd0:   b = seq_sel[31:24];
      16'd1:   b = seq_sel[23:16];
      16'd2:   b = seq_sel[15:8];
      16'd3:   b = seq_sel[7:0];
      16'd4:   b = ts_lat[63:56];
      16'd5:   b = ts_lat[55:48];
      16'd6:   b = ts_lat[47:40];
      16'd7:   b = ts_lat[39:32];
      16'd8:   b = ts_lat[31:24];
      16'd9:   b = ts_lat[23:16];
      16'd10:  b = ts_lat[15:8];
      16'd11:  b = ts_lat[7:0];
      16'd12:  b = bits[15:8];
      16'd13:  b = bits[7:0];
      16'd14:  b = spf_lat[15:8];
      16'd15:  b = spf_lat[7:0];
      default: b = rx_sel;
    endcase
    return b;
  endfunction

  // ---- FSM: state register ----
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run && fifo_ready[ptr]) state_nxt = LOAD;
      LOAD:    state_nxt = REQ;
      REQ:     if (udp_tx_enable) state_nxt = SEND;
      SEND:    if (last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  // ---- FSM: combinational outputs ----
  always_comb begin
    fifo_rdreq = '0;
    if ((state == SEND) && udp_tx_active && rd_window && !timeout)
      fifo_rdreq[sel] = 1'b1;
    phy_ready = (state == IDLE) && !(|fifo_ready);
  end

  // ---- timestamp: free-running while run is high ----
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n)  ts <= '0;
    else if (run)  ts <= ts + 64'd1;
    else           ts <= '0;
  end

  // ---- round-robin scan: one stream examined per IDLE cycle ----
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      sel <= '0;
    end else if (!run) begin
      ptr <= '0;
    end else if (state == IDLE) begin
      if (fifo_ready[ptr]) sel <= ptr;
      ptr <= ptr_next;
    end
  end

  // ---- packet setup: width, length, timestamp and port latched in LOAD ----
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      udp_tx_length <= '0;
      port_ID       <= '0;
      ts_lat        <= '0;
      s24_lat       <= 1'b0;
      spf_lat       <= '0;
    end else if (state == LOAD) begin
      udp_tx_length <= 16'd16 + samples_per_frame * (sample24 ? 16'd6 : 16'd4);
      port_ID       <= 8'(PORT_BASE) + 8'(sel);
      ts_lat        <= ts;
      s24_lat       <= sample24;
      spf_lat       <= samples_per_frame;
    end
  end

  // ---- byte engine: request handshake and byte sequencing ----
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      udp_tx_request <= 1'b0;
      udp_tx_data    <= '0;
      byte_no        <= '0;
    end else if (timeout) begin
      udp_tx_request <= 1'b0;
    end else begin
      case (state)
        LOAD: udp_tx_request <= 1'b1;
        REQ: begin
          if (udp_tx_enable) begin
            byte_no     <= '0;
            udp_tx_data <= frame_byte(16'd0);
          end
        end
        SEND: begin
          if (last_byte) begin
            udp_tx_request <= 1'b0;
          end else if (udp_tx_active) begin
            byte_no     <= byte_no + 16'd1;
            udp_tx_data <= frame_byte(byte_no + 16'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---- sequence counters: bump on a completed packet, clear when stopped ----
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NR; k++) seq[k] <= '0;
    end else if ((state == IDLE) && !run) begin
      for (int k = 0; k < NR; k++) seq[k] <= '0;
    end else if (last_byte && !timeout) begin
      seq[sel] <= seq[sel] + 32'd1;
    end
  end

  // ---- watchdog: counts cycles stuck outside IDLE with run low ----
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n)                              wd <= '0;
    else if ((state == IDLE) || run || timeout) wd <= '0;
    else                                       wd <= wd + WW'(1);
  end

endmodule

// File: tb/tb_ddc_stream_sender.sv
// Directed bench for ddc_stream_sender (NR=4, PORT_BASE=11, TIMEOUT=100).
// The bench acts as the UDP transmitter and as the stream FIFOs. Each FIFO
// delivers a fixed byte pattern. Its output trails the read strobe by two
// consumed bytes.
module tb_ddc_stream_sender;
  localparam int NR        = 4;
  localparam int PORT_BASE = 11;
  localparam int TIMEOUT   = 100;

  logic            tx_clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            run = 1'b0;
  logic            sample24 = 1'b0;
  logic [15:0]     samples_per_frame = '0;
  logic [NR-1:0]   fifo_ready = '0;
  logic [8*NR-1:0] rx_data;
  logic            udp_tx_enable = 1'b0;
  logic            udp_tx_active = 1'b0;
  logic            udp_tx_request;
  logic [15:0]     udp_tx_length;
  logic [7:0]      udp_tx_data;
  logic [7:0]      port_ID;
  logic [NR-1:0]   fifo_rdreq;
  logic            phy_ready;

  int vectors = 0;
  int miscompares = 0;

  ddc_stream_sender #(.NR(NR), .PORT_BASE(PORT_BASE), .TIMEOUT(TIMEOUT)) dut (
    .tx_clock(tx_clock), .reset_n(reset_n), .run(run), .sample24(sample24),
    .samples_per_frame(samples_per_frame), .fifo_ready(fifo_ready), .rx_data(rx_data),
    .udp_tx_enable(udp_tx_enable), .udp_tx_active(udp_tx_active),
    .udp_tx_request(udp_tx_request), .udp_tx_length(udp_tx_length),
    .udp_tx_data(udp_tx_data), .port_ID(port_ID), .fifo_rdreq(fifo_rdreq),
    .phy_ready(phy_ready));

  always #5 tx_clock = ~tx_clock;

  // Stream FIFO model: element idx of stream k has value fval(k, idx).
  function automatic logic [7:0] fval(input int k, input int idx);
    return 8'((idx * 7) + (k * 53) + 1);
  endfunction

  int            rdcnt [NR] = '{default: 0};
  int            stray = 0;
  logic [NR-1:0] cur_mask = '0;
  logic [NR-1:0] rd_q = '0;
  logic          act_q = 1'b0;
  logic [7:0]    s1 = '0, s2 = '0;
  logic [7:0]    pkt [0:2047];

  assign rx_data = {NR{s2}};

  // Snapshot strobe/active mid-cycle; flag reads while stalled or on another stream.
  always @(negedge tx_clock) begin
    #2;
    act_q = udp_tx_active;
    rd_q  = fifo_rdreq;
    if (((rd_q & ~cur_mask) != '0) || (!act_q && (rd_q != '0))) stray++;
  end

  always @(posedge tx_clock) begin
    if (act_q) begin
      s2 <= s1;
      for (int k = 0; k < NR; k++)
        if (rd_q[k]) begin
          s1 <= fval(k, rdcnt[k]);
          rdcnt[k] <= rdcnt[k] + 1;
        end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_packet(input int k, input int len, input logic [31:0] seq_exp,
                             input int bits_exp, input int spf_exp, input int stall_pct,
                             input bit keep_ready, input bit drop_run,
                             input bit ts_chk, input logic [63:0] ts_exp);
    int guard, i, base, stray0, bad;
    guard = 0;
    while (udp_tx_request !== 1'b1 && guard < 40) begin
      @(negedge tx_clock);
      guard++;
    end
    chk("request_seen", {63'd0, udp_tx_request}, 64'd1);
    if (udp_tx_request !== 1'b1) return;
    chk("port_ID", {56'd0, port_ID}, 64'(PORT_BASE + k));
    chk("length", {48'd0, udp_tx_length}, 64'(len));
    base = rdcnt[k];
    stray0 = stray;
    cur_mask = NR'(1) << k;
    udp_tx_enable = 1'b1;
    if (!keep_ready) fifo_ready = '0;
    @(negedge tx_clock);
    udp_tx_enable = 1'b0;
    if (drop_run) run = 1'b0;
    i = 0;
    guard = 0;
    while (i < len && guard < 20000) begin
      udp_tx_active = ($urandom_range(99) >= stall_pct);
      #1;
      if (udp_tx_active) begin
        pkt[i] = udp_tx_data;
        i++;
      end
      @(negedge tx_clock);
      guard++;
    end
    udp_tx_active = 1'b0;
    chk("bytes_consumed", 64'(i), 64'(len));
    guard = 0;
    while (udp_tx_request !== 1'b0 && guard < 5) begin
      @(negedge tx_clock);
      guard++;
    end
    chk("request_drop", {63'd0, udp_tx_request}, 64'd0);
    chk("hdr_seq", {32'd0, pkt[0], pkt[1], pkt[2], pkt[3]}, {32'd0, seq_exp});
    if (ts_chk)
      chk("hdr_timestamp", {pkt[4], pkt[5], pkt[6], pkt[7], pkt[8], pkt[9], pkt[10], pkt[11]},
          ts_exp);
    chk("hdr_bits", {48'd0, pkt[12], pkt[13]}, 64'(bits_exp));
    chk("hdr_spf", {48'd0, pkt[14], pkt[15]}, 64'(spf_exp));
    bad = 0;
    for (int j = 16; j < len; j++)
      if (pkt[j] !== fval(k, base + j - 16)) bad++;
    chk("payload_errors", 64'(bad), 64'd0);
    chk("read_count", 64'(rdcnt[k] - base), 64'(len - 16));
    chk("stray_reads", 64'(stray - stray0), 64'd0);
  endtask

  initial begin
    int guard;
    // Reset state
    #1;
    chk("rst_request", {63'd0, udp_tx_request}, 64'd0);
    chk("rst_length", {48'd0, udp_tx_length}, 64'd0);
    chk("rst_data", {56'd0, udp_tx_data}, 64'd0);
    chk("rst_port", {56'd0, port_ID}, 64'd0);
    chk("rst_rdreq", {60'd0, fifo_rdreq}, 64'd0);
    chk("rst_phy_ready", {63'd0, phy_ready}, 64'd1);
    @(negedge tx_clock);
    reset_n = 1'b1;
    repeat (2) @(negedge tx_clock);

    // 24-bit, 238 samples on stream 2: 2-cycle latency after the scan reaches p=2
    run = 1'b1;
    sample24 = 1'b1;
    samples_per_frame = 16'd238;
    fifo_ready = 4'b0100;
    repeat (3) @(negedge tx_clock);
    chk("latency_not_yet", {63'd0, udp_tx_request}, 64'd0);
    @(negedge tx_clock);
    chk("latency_request", {63'd0, udp_tx_request}, 64'd1);
    send_packet(2, 1444, 32'd0, 24, 238, 0, 1'b0, 1'b0, 1'b1, 64'd3);

    // 16-bit, 255 samples on stream 0 with random stalls
    sample24 = 1'b0;
    samples_per_frame = 16'd255;
    fifo_ready = 4'b0001;
    send_packet(0, 1036, 32'd0, 16, 255, 30, 1'b0, 1'b0, 1'b0, 64'd0);

    // Second packet on stream 2 carries seq 1
    sample24 = 1'b1;
    samples_per_frame = 16'd2;
    fifo_ready = 4'b0100;
    send_packet(2, 28, 32'd1, 24, 2, 0, 1'b0, 1'b0, 1'b0, 64'd0);

    // All streams ready: pointer order, per-stream sequence without gaps
    run = 1'b0;
    repeat (2) @(negedge tx_clock);
    sample24 = 1'b0;
    samples_per_frame = 16'd3;
    run = 1'b1;
    fifo_ready = 4'b1111;
    for (int n = 0; n < 6; n++)
      send_packet(n % 4, 28, 32'(n / 4), 16, 3, 25, (n < 5), 1'b0, 1'b0, 64'd0);

    // run falls just after the grant; packet still completes
    fifo_ready = 4'b1000;
    send_packet(3, 28, 32'd1, 16, 3, 0, 1'b0, 1'b1, 1'b0, 64'd0);

    // Watchdog: run drops in REQ with no grant
    repeat (2) @(negedge tx_clock);
    run = 1'b1;
    fifo_ready = 4'b0010;
    guard = 0;
    while (udp_tx_request !== 1'b1 && guard < 40) begin
      @(negedge tx_clock);
      guard++;
    end
    chk("wd_request_seen", {63'd0, udp_tx_request}, 64'd1);
    fifo_ready = '0;
    run = 1'b0;
    repeat (99) @(negedge tx_clock);
    chk("wd_before_timeout", {63'd0, udp_tx_request}, 64'd1);
    @(negedge tx_clock);
    chk("wd_after_timeout", {63'd0, udp_tx_request}, 64'd0);
    chk("wd_phy_ready", {63'd0, phy_ready}, 64'd1);
    run = 1'b1;
    fifo_ready = 4'b0010;
    send_packet(1, 28, 32'd0, 16, 3, 0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Asynchronous reset in the middle of SEND
    run = 1'b0;
    repeat (2) @(negedge tx_clock);
    run = 1'b1;
    fifo_ready = 4'b0100;
    guard = 0;
    while (udp_tx_request !== 1'b1 && guard < 40) begin
      @(negedge tx_clock);
      guard++;
    end
    chk("rst2_request_seen", {63'd0, udp_tx_request}, 64'd1);
    udp_tx_enable = 1'b1;
    @(negedge tx_clock);
    udp_tx_enable = 1'b0;
    udp_tx_active = 1'b1;
    repeat (5) @(negedge tx_clock);
    udp_tx_active = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst2_request", {63'd0, udp_tx_request}, 64'd0);
    chk("rst2_data", {56'd0, udp_tx_data}, 64'd0);
    chk("rst2_length", {48'd0, udp_tx_length}, 64'd0);
    chk("rst2_port", {56'd0, port_ID}, 64'd0);
    chk("rst2_rdreq", {60'd0, fifo_rdreq}, 64'd0);
    @(negedge tx_clock);
    reset_n = 1'b1;
    send_packet(2, 28, 32'd0, 16, 3, 0, 1'b0, 1'b0, 1'b1, 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
